// File: rtl/sram_memory_controller_pkg.sv
// ============================================================================
// Module : sram_memory_controller_pkg
// Brief  : Shared state encodings and default sizing for the SRAM memory stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_memory_controller_pkg;

  typedef enum logic [1:0] {
    SM_IDLE   = 2'd0,
    SM_ACCESS = 2'd1,
    SM_DONE   = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_SRAM_DATA_WIDTH = 16;
  localparam int DEFAULT_SRAM_ADDR_WIDTH = 18;
  localparam int DEFAULT_WAIT_CYCLES     = 5;
  localparam int DEFAULT_ADDR_BASE       = 1024;

endpackage

`default_nettype wire

// File: rtl/sram_memory_controller_beat_counter.sv
// ============================================================================
// Module : sram_beat_counter
// Brief  : Nested wait-state / beat counter; wraps to zero after the last beat.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_beat_counter #(
  parameter int WAIT_CYCLES = 5,
  parameter int BEATS       = 2,
  parameter int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              busy_i,
  output logic [BEAT_W-1:0] beat_cnt_o,
  output logic              last_cycle_o,
  output logic              last_beat_o
);

  localparam int WAIT_W = $clog2(WAIT_CYCLES);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [BEAT_W-1:0] beat_cnt_q;

  assign last_cycle_o = (wait_cnt_q == WAIT_W'(WAIT_CYCLES - 1));
  assign last_beat_o  = (beat_cnt_q == BEAT_W'(BEATS - 1));
  assign beat_cnt_o   = beat_cnt_q;

  // The request cycle itself is wait state 0 of beat 0, hence start_i counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else if (start_i || busy_i) begin
      if (last_cycle_o) begin
        wait_cnt_q <= '0;
        beat_cnt_q <= last_beat_o ? '0 : beat_cnt_q + BEAT_W'(1);
      end else begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_memory_controller.sv
// ============================================================================
// Module : sram_memory_controller
// Brief  : Memory-stage controller splitting each pipeline word into SRAM beats.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_memory_controller
  import sram_memory_controller_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int SRAM_DATA_WIDTH = DEFAULT_SRAM_DATA_WIDTH,
  parameter int SRAM_ADDR_WIDTH = DEFAULT_SRAM_ADDR_WIDTH,
  parameter int WAIT_CYCLES     = DEFAULT_WAIT_CYCLES,
  parameter int ADDR_BASE       = DEFAULT_ADDR_BASE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [31:0]                address,
  input  logic [DATA_WIDTH-1:0]      write_data,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
  output logic                       sram_dq_oe,
  output logic                       sram_we_n
);

  localparam int BEATS      = DATA_WIDTH / SRAM_DATA_WIDTH;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  if ((DATA_WIDTH % SRAM_DATA_WIDTH) != 0 || WAIT_CYCLES < 2) begin : g_bad_params
    $error("sram_memory_controller: illegal DATA_WIDTH/SRAM_DATA_WIDTH/WAIT_CYCLES");
  end

  state_t                state_q;
  logic                  op_write_q;
  logic [31:0]           word_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rbuf_q;
  logic [DATA_WIDTH-1:0] rbuf_d;
  logic [DATA_WIDTH-1:0] read_data_q;

  logic [BEAT_W-1:0]     beat_cnt;
  logic                  last_cycle;
  logic                  last_beat;

  logic                  req;
  logic                  idle;
  logic                  busy;
  logic                  start;
  logic                  drive;
  logic                  cur_write;
  logic [31:0]           req_word;
  logic [31:0]           cur_word;
  logic [31:0]           sram_word;
  logic [DATA_WIDTH-1:0] cur_wdata;

  assign req   = rd_en | wr_en;
  assign idle  = (state_q == SM_IDLE);
  assign busy  = (state_q == SM_ACCESS);
  assign start = idle & req;
  assign ready = (idle & ~req) | (state_q == SM_DONE);

  // The request cycle already drives beat 0 from the live inputs; afterwards
  // the latched copies take over.
  assign req_word  = (address - 32'(ADDR_BASE)) >> BYTE_SHIFT;
  assign cur_word  = idle ? req_word   : word_addr_q;
  assign cur_write = idle ? wr_en      : op_write_q;
  assign cur_wdata = idle ? write_data : wdata_q;
  assign sram_word = cur_word * 32'(BEATS) + 32'(beat_cnt);
  assign drive     = (start | busy) & ~rst;

  assign sram_addr   = drive ? sram_word[SRAM_ADDR_WIDTH-1:0] : '0;
  assign sram_dq_oe  = drive & cur_write;
  assign sram_dq_out = (drive & cur_write)
                     ? cur_wdata[int'(beat_cnt)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] : '0;
  assign sram_we_n   = ~(drive & cur_write & ~last_cycle);
  assign read_data   = read_data_q;

  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[int'(beat_cnt)*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] = sram_dq_in;
  end

  sram_beat_counter #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .BEATS       (BEATS),
    .BEAT_W      (BEAT_W)
  ) u_beat_counter (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .busy_i       (busy),
    .beat_cnt_o   (beat_cnt),
    .last_cycle_o (last_cycle),
    .last_beat_o  (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SM_IDLE;
      op_write_q  <= 1'b0;
      word_addr_q <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      read_data_q <= '0;
    end else begin
      case (state_q)
        SM_IDLE: begin
          if (req) begin
            state_q     <= SM_ACCESS;
            op_write_q  <= wr_en;
            word_addr_q <= req_word;
            wdata_q     <= write_data;
          end
        end
        SM_ACCESS: begin
          if (!op_write_q && last_cycle) begin
            rbuf_q <= rbuf_d;
            if (last_beat) begin
              read_data_q <= rbuf_d;
            end
          end
          if (last_cycle && last_beat) begin
            state_q <= SM_DONE;
          end
        end
        SM_DONE: state_q <= SM_IDLE;
        default: state_q <= SM_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sram_memory_controller.md
Name: sram_memory_controller

Overview:
Parametrised multi-cycle memory-stage controller. It replaces the single-cycle data memory behind the memory stage with an external narrow SRAM. It splits each DATA_WIDTH word into BEATS = DATA_WIDTH/SRAM_DATA_WIDTH SRAM beats, each with a programmable wait-state count. It drives ready low to freeze the whole pipeline until the access completes.

Parameters:
DATA_WIDTH, 32, pipeline word width; must be an integer multiple of SRAM_DATA_WIDTH.
SRAM_DATA_WIDTH, 16, external SRAM data bus width.
SRAM_ADDR_WIDTH, 18, external SRAM address width, in SRAM-word units.
WAIT_CYCLES, 5, cycles per SRAM beat; must be >= 2.
ADDR_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
rd_en  in  1  read request from the memory stage.
wr_en  in  1  write request from the memory stage.
address  in  32  byte address (ALU result).
write_data  in  DATA_WIDTH  store data (valRm).
read_data  out  DATA_WIDTH  load data; valid while ready=1 in DONE.
ready  out  1  1 = the pipeline may advance; 0 = freeze all stages.
sram_addr  out  SRAM_ADDR_WIDTH  SRAM word address.
sram_dq_out  out  SRAM_DATA_WIDTH  write data to the SRAM.
sram_dq_in  in  SRAM_DATA_WIDTH  read data from the SRAM.
sram_dq_oe  out  1  1 = controller drives the data bus.
sram_we_n  out  1  active-low SRAM write strobe.

Behaviour:
- Reset values (held for every cycle rst=1):
  - state=IDLE; counters=0.
  - read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - ready=1 unless a request is present.
- States: IDLE, ACCESS, DONE.
- ready is combinational: ready = (IDLE and !(rd_en|wr_en)) | DONE. It falls in the same cycle a request appears, so no pipeline stage advances.
- Request priority: if rd_en and wr_en are both 1, the access is a write.
- Requester contract: rd_en, wr_en, address and write_data are held stable while ready=0. The controller latches them on IDLE->ACCESS anyway and ignores later changes.
- IDLE -> ACCESS on (rd_en|wr_en). Latches op, word_addr and write_data.
  - word_addr = ((address - ADDR_BASE) mod 2^32) >> log2(DATA_WIDTH/8).
  - Addresses below ADDR_BASE wrap; the result is truncated to SRAM_ADDR_WIDTH.
- ACCESS runs BEATS beats, beat index b = 0..BEATS-1, low slice first.
  - Each beat lasts WAIT_CYCLES cycles, counted by wait_cnt = 0..WAIT_CYCLES-1.
  - sram_addr = word_addr*BEATS + b, truncated to SRAM_ADDR_WIDTH, stable for the whole beat.
- Write beat:
  - sram_dq_oe=1 for the whole beat; sram_dq_out = write_data slice b.
  - sram_we_n=0 for wait_cnt 0..WAIT_CYCLES-2 and 1 on the final cycle (data hold).
- Read beat:
  - sram_dq_oe=0, sram_we_n=1.
  - sram_dq_in is sampled into read slice b on wait_cnt = WAIT_CYCLES-1.
- ACCESS -> DONE after the last cycle of beat BEATS-1.
- DONE lasts exactly 1 cycle:
  - ready=1; read_data holds the assembled word (read) or is unchanged (write).
  - sram_we_n=1, sram_dq_oe=0.
  - DONE -> IDLE unconditionally. The pipeline advances in this cycle; a new request is seen in IDLE on the next cycle.
- Latency: ready=0 for BEATS*WAIT_CYCLES cycles (10 by default), starting in the request cycle; ready=1 on the following cycle (DONE).
- read_data holds its last value until the next completed read.
- A flush never aborts an access: memory-stage requests are past the flush point.
- rst mid-ACCESS: return to IDLE next cycle with reset values.
  - A partial write may have reached the SRAM; this is accepted.
  - read_data is cleared to 0.
- BEATS=1 is legal and degenerates to one beat.
- Elaboration error if DATA_WIDTH % SRAM_DATA_WIDTH != 0 or WAIT_CYCLES < 2.

Decomposition:
- Shared header with:
  - state encodings SM_IDLE=2'd0, SM_ACCESS=2'd1, SM_DONE=2'd2;
  - default widths, WAIT_CYCLES and ADDR_BASE.
  These are also used by the top-level pipeline for freeze wiring.
- One sub-module, sram_beat_counter: nested wait_cnt/beat_cnt with start, last_cycle and last_beat outputs, parametrised by WAIT_CYCLES and BEATS.
- At top level, ready replaces hazard as the freeze term for the register after the memory stage and for all earlier stages.

Test Plan:
- Default parameters, wr_en, address=1024, write_data=32'hDEADBEEF -> ready=0 for 10 cycles.
  - sram_addr=0 with sram_dq_out=16'hBEEF, then sram_addr=1 with 16'hDEAD.
  - sram_we_n low for 4 cycles per beat.
  - DONE pulse on cycle 11.
- Read of address 1024 against an SRAM model holding that data -> read_data=32'hDEADBEEF while ready=1 in DONE; ready=0 for exactly 10 cycles.
- Simultaneous rd_en=wr_en=1 at address 1028 -> write beats at sram_addr 2 and 3; read_data unchanged.
- Assert rst at cycle 3 of an ACCESS -> next cycle IDLE, sram_we_n=1, sram_dq_oe=0, read_data=0, ready=1 with no request.
- DATA_WIDTH=32, SRAM_DATA_WIDTH=32, WAIT_CYCLES=2, read address 1032 -> one beat at sram_addr=2; ready low for 2 cycles.
- Address 1020 (below ADDR_BASE) -> word_addr wraps; sram_addr = all-ones*2 truncated = 18'h3FFFE, then 18'h3FFFF.
